gb_lcd_frame_writer: RTL and testbench

Captures the PPU pixel stream (2-bit shade per pixel) in the GameBoy clock domain and writes it into the 160x144 LCD frame buffer that the VGA scaler reads. It generates linear write addresses, owns the double-buffer bank select, blanks the buffer on reset and LCD-off, and flags malformed lines or frames. It sits between the PPU pixel conduit and the dual-clock frame buffer RAM.

---
 rtl/gb_lcd_frame_writer_if.sv | 44 ++++
 rtl/gb_lcd_frame_writer.sv | 191 +++++++++++++++++++
 tb/tb_gb_lcd_frame_writer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_lcd_frame_writer_if.sv
// ---------------------------------------------------------------------------
// gb_lcd_frame_writer_if
// Bundles the PPU pixel conduit and the frame buffer write port that
// gb_lcd_frame_writer sits between.
//   master : PPU / bench side (drives LCD_ON, LD, PX_VALID, PPU_HSYNC,
//            PPU_VSYNC, ERR_CLR; observes everything else)
//   slave  : the frame writer (drives FB_WE, FB_ADDR, FB_DATA, FB_SEL,
//            FRAME_DONE, LINE_CNT, ERR_FLAGS, DBG_STATE)
// Handshake: there is no back-pressure. A pixel is transferred in every
// GameBoy_clk cycle where PX_VALID=1; FB_WE=1 marks a write the RAM must
// accept in that cycle. PPU_HSYNC/PPU_VSYNC/ERR_CLR are single-cycle pulses.
// DBG_STATE exposes the writer FSM state (0 CLEAR, 1 OFF, 2 WAIT_FRAME,
// 3 ACTIVE).
// ---------------------------------------------------------------------------
interface gb_lcd_frame_writer_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  LCD_ON;
  logic [1:0]            LD;
  logic                  PX_VALID;
  logic                  PPU_HSYNC;
  logic                  PPU_VSYNC;
  logic                  ERR_CLR;
  logic                  FB_WE;
  logic [ADDR_WIDTH-1:0] FB_ADDR;
  logic [1:0]            FB_DATA;
  logic                  FB_SEL;
  logic                  FRAME_DONE;
  logic [7:0]            LINE_CNT;
  logic [2:0]            ERR_FLAGS;
  logic [1:0]            DBG_STATE;

  modport master (
    output LCD_ON, LD, PX_VALID, PPU_HSYNC, PPU_VSYNC, ERR_CLR,
    input  FB_WE, FB_ADDR, FB_DATA, FB_SEL, FRAME_DONE, LINE_CNT, ERR_FLAGS,
           DBG_STATE
  );

  modport slave (
    input  LCD_ON, LD, PX_VALID, PPU_HSYNC, PPU_VSYNC, ERR_CLR,
    output FB_WE, FB_ADDR, FB_DATA, FB_SEL, FRAME_DONE, LINE_CNT, ERR_FLAGS,
           DBG_STATE
  );
endinterface

// File: rtl/gb_lcd_frame_writer.sv
// ---------------------------------------------------------------------------
// gb_lcd_frame_writer
// Captures the PPU 2-bit pixel stream and writes it linearly (y*WIDTH+x)
// into the double-buffered LCD frame buffer read by the VGA scaler.
// Owns the bank select (FB_SEL = bank being written, display reads ~FB_SEL),
// blanks the current bank after reset and LCD-off, and records sticky
// errors: [0] line overrun, [1] line underrun, [2] short frame.
// Ports:
//   GameBoy_clk   : GameBoy clock (2^22 Hz)
//   GameBoy_reset : asynchronous, active-high reset
//   lcd           : gb_lcd_frame_writer_if.slave (pixel conduit in,
//                   frame buffer write port / status out)
// All outputs are registered.
// ---------------------------------------------------------------------------
module gb_lcd_frame_writer #(
  parameter int         WIDTH       = 160,
  parameter int         HEIGHT      = 144,
  parameter int         ADDR_WIDTH  = 15,
  parameter logic [1:0] BLANK_SHADE = 2'b00
) (
  input logic                 GameBoy_clk,
  input logic                 GameBoy_reset,
  gb_lcd_frame_writer_if.slave lcd
);

  localparam logic [1:0] ST_CLEAR  = 2'd0;
  localparam logic [1:0] ST_OFF    = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_ACTIVE = 2'd3;

  localparam logic [7:0]            LP_W     = 8'(WIDTH);
  localparam logic [7:0]            LP_H     = 8'(HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LP_WA    = ADDR_WIDTH'(WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LP_TOTAL = ADDR_WIDTH'(WIDTH * HEIGHT);

  logic [1:0]            r_state, w_state;
  logic [7:0]            r_x, w_x;
  logic [7:0]            r_y, w_y;
  // r_addr is the next pixel address in ACTIVE and the clear counter in CLEAR
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  // start address of the current line; HSYNC adds WIDTH instead of multiplying
  logic [ADDR_WIDTH-1:0] r_line_base, w_line_base;
  logic                  r_fb_we, w_fb_we;
  logic [ADDR_WIDTH-1:0] r_fb_addr, w_fb_addr;
  logic [1:0]            r_fb_data, w_fb_data;
  logic                  r_fb_sel, w_fb_sel;
  logic                  r_frame_done, w_frame_done;
  logic [2:0]            r_err, w_err, w_err_set;

  always_comb begin
    w_state      = r_state;
    w_x          = r_x;
    w_y          = r_y;
    w_addr       = r_addr;
    w_line_base  = r_line_base;
    w_fb_we      = 1'b0;
    w_fb_addr    = r_fb_addr;
    w_fb_data    = r_fb_data;
    w_fb_sel     = r_fb_sel;
    w_frame_done = 1'b0;
    w_err_set    = 3'b000;

    case (r_state)
      ST_CLEAR: begin
        // LCD_ON is only looked at once the whole bank is blank
        if (r_addr == LP_TOTAL) begin
          w_fb_sel     = ~r_fb_sel;
          w_frame_done = 1'b1;
          w_addr       = '0;
          w_state      = lcd.LCD_ON ? ST_WAIT : ST_OFF;
        end else begin
          w_fb_we   = 1'b1;
          w_fb_addr = r_addr;
          w_fb_data = BLANK_SHADE;
          w_addr    = r_addr + 1'b1;
        end
      end

      ST_OFF: begin
        if (lcd.LCD_ON) w_state = ST_WAIT;
      end

      ST_WAIT: begin
        if (!lcd.LCD_ON) begin
          w_state     = ST_CLEAR;
          w_addr      = '0;
          w_line_base = '0;
          w_x         = '0;
          w_y         = '0;
        end else if (lcd.PPU_VSYNC) begin
          // the frame in flight at LCD enable is dropped; start clean here
          w_state     = ST_ACTIVE;
          w_addr      = '0;
          w_line_base = '0;
          w_x         = '0;
          w_y         = '0;
        end
      end

      default: begin // ST_ACTIVE
        if (!lcd.LCD_ON) begin
          // abandon the partial frame and blank the bank being written
          w_state     = ST_CLEAR;
          w_addr      = '0;
          w_line_base = '0;
          w_x         = '0;
          w_y         = '0;
        end else begin
          // same-cycle events: pixel (old x/y), then HSYNC, then VSYNC
          if (lcd.PX_VALID) begin
            if (r_x < LP_W && r_y < LP_H) begin
              w_fb_we   = 1'b1;
              w_fb_addr = r_addr;
              w_fb_data = lcd.LD;
              w_x       = r_x + 1'b1;
              w_addr    = r_addr + 1'b1;
            end else begin
              w_err_set[0] = 1'b1;
            end
          end
          if (lcd.PPU_HSYNC) begin
            if (r_y < LP_H) begin
              // w_x already includes a pixel accepted in this same cycle
              if (w_x != LP_W) w_err_set[1] = 1'b1;
              w_x         = '0;
              w_y         = r_y + 1'b1;
              w_line_base = r_line_base + LP_WA;
              w_addr      = r_line_base + LP_WA;
            end else begin
              w_err_set[0] = 1'b1;
            end
          end
          if (lcd.PPU_VSYNC) begin
            if (w_y == LP_H) begin
              w_fb_sel     = ~r_fb_sel;
              w_frame_done = 1'b1;
            end else begin
              // short frame: keep the bank and overwrite it next frame
              w_err_set[2] = 1'b1;
            end
            w_x         = '0;
            w_y         = '0;
            w_addr      = '0;
            w_line_base = '0;
          end
        end
      end
    endcase

    // a set event in the ERR_CLR cycle survives the clear
    w_err = (lcd.ERR_CLR ? 3'b000 : r_err) | w_err_set;
  end

  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) begin
      r_state      <= ST_CLEAR;
      r_x          <= '0;
      r_y          <= '0;
      r_addr       <= '0;
      r_line_base  <= '0;
      r_fb_we      <= 1'b0;
      r_fb_addr    <= '0;
      r_fb_data    <= 2'b00;
      r_fb_sel     <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 3'b000;
    end else begin
      r_state      <= w_state;
      r_x          <= w_x;
      r_y          <= w_y;
      r_addr       <= w_addr;
      r_line_base  <= w_line_base;
      r_fb_we      <= w_fb_we;
      r_fb_addr    <= w_fb_addr;
      r_fb_data    <= w_fb_data;
      r_fb_sel     <= w_fb_sel;
      r_frame_done <= w_frame_done;
      r_err        <= w_err;
    end
  end

  assign lcd.FB_WE      = r_fb_we;
  assign lcd.FB_ADDR    = r_fb_addr;
  assign lcd.FB_DATA    = r_fb_data;
  assign lcd.FB_SEL     = r_fb_sel;
  assign lcd.FRAME_DONE = r_frame_done;
  assign lcd.LINE_CNT   = r_y;
  assign lcd.ERR_FLAGS  = r_err;
  assign lcd.DBG_STATE  = r_state;

endmodule

// File: tb/tb_gb_lcd_frame_writer.sv
module tb_gb_lcd_frame_writer;
  localparam int W     = 160;
  localparam int H     = 144;
  localparam int TOTAL = W * H;

  localparam logic [1:0] S_CLEAR  = 2'd0;
  localparam logic [1:0] S_OFF    = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACTIVE = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gb_lcd_frame_writer_if #(.ADDR_WIDTH(15)) lcd ();

  gb_lcd_frame_writer #(
    .WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(15), .BLANK_SHADE(2'b00)
  ) dut (
    .GameBoy_clk  (clk),
    .GameBoy_reset(rst),
    .lcd          (lcd)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] exp_q[$];     // {addr[14:0], data[1:0]} of each expected write
  logic [16:0] mon_e;
  logic [14:0] last_addr = '0;
  logic [1:0]  last_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every frame buffer write must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && lcd.FB_WE === 1'b1) begin
      check("write_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("fb_write", {15'd0, lcd.FB_ADDR, lcd.FB_DATA}, {15'd0, mon_e});
      end
      last_addr = lcd.FB_ADDR;
      last_data = lcd.FB_DATA;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic px, input logic [1:0] ld, input logic hs,
                      input logic vs, input logic clr);
    lcd.PX_VALID  = px;
    lcd.LD        = ld;
    lcd.PPU_HSYNC = hs;
    lcd.PPU_VSYNC = vs;
    lcd.ERR_CLR   = clr;
    @(posedge clk);
    #1;
    lcd.PX_VALID  = 1'b0;
    lcd.PPU_HSYNC = 1'b0;
    lcd.PPU_VSYNC = 1'b0;
    lcd.ERR_CLR   = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic [1:0] ld);
    exp_q.push_back({15'(y * W + x), ld});
    step(1'b1, ld, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_clear();
    for (int a = 0; a < TOTAL; a++) exp_q.push_back({15'(a), 2'b00});
  endtask

  // counts edges until FRAME_DONE; optionally wiggles LCD_ON mid-clear
  task automatic wait_done(input int glitch_at, output int n);
    n = 0;
    while (n < 30000) begin
      @(posedge clk);
      #1;
      n++;
      if (glitch_at != 0 && n == glitch_at) lcd.LCD_ON = ~lcd.LCD_ON;
      if (glitch_at != 0 && n == glitch_at + 5) lcd.LCD_ON = ~lcd.LCD_ON;
      if (lcd.FRAME_DONE === 1'b1) break;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst           = 1'b1;
    lcd.LCD_ON    = 1'b1;
    lcd.LD        = 2'b00;
    lcd.PX_VALID  = 1'b0;
    lcd.PPU_HSYNC = 1'b0;
    lcd.PPU_VSYNC = 1'b0;
    lcd.ERR_CLR   = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset values
    check("rst_fb_we",   32'(lcd.FB_WE), 0);
    check("rst_fb_addr", 32'(lcd.FB_ADDR), 0);
    check("rst_fb_data", 32'(lcd.FB_DATA), 0);
    check("rst_fb_sel",  32'(lcd.FB_SEL), 0);
    check("rst_done",    32'(lcd.FRAME_DONE), 0);
    check("rst_line",    32'(lcd.LINE_CNT), 0);
    check("rst_err",     32'(lcd.ERR_FLAGS), 0);
    check("rst_state",   32'(lcd.DBG_STATE), 32'(S_CLEAR));

    // power-up clear; an LCD_ON glitch mid-clear must not disturb it
    push_clear();
    rst = 1'b0;
    wait_done(100, n);
    check("clear_cycles",  n, 32'd23041);
    check("clear_sel",     32'(lcd.FB_SEL), 1);
    check("clear_we_low",  32'(lcd.FB_WE), 0);
    check("clear_state",   32'(lcd.DBG_STATE), 32'(S_WAIT));
    check("clear_all_wr",  32'(exp_q.size()), 0);
    check("clear_last",    32'({last_addr, last_data}), 32'({15'd23039, 2'b00}));
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    check("done_one_cyc",  32'(lcd.FRAME_DONE), 0);

    // WAIT_FRAME ignores pixels and HSYNC
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
    check("wait_state", 32'(lcd.DBG_STATE), 32'(S_WAIT));
    check("wait_err",   32'(lcd.ERR_FLAGS), 0);
    check("wait_line",  32'(lcd.LINE_CNT), 0);
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    check("active_state", 32'(lcd.DBG_STATE), 32'(S_ACTIVE));
    check("active_sel",   32'(lcd.FB_SEL), 1);

    // full frame: 144 lines of 160 pixels, LD = x[1:0]
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) pix(x, y, 2'(x));
      step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    end
    check("frame_line144", 32'(lcd.LINE_CNT), 32'd144);
    check("frame_err_pre", 32'(lcd.ERR_FLAGS), 0);
    check("frame_all_wr",  32'(exp_q.size()), 0);
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    check("frame_done",    32'(lcd.FRAME_DONE), 1);
    check("frame_sel",     32'(lcd.FB_SEL), 0);
    check("frame_last",    32'({last_addr, last_data}), 32'({15'd23039, 2'b11}));
    check("frame_err",     32'(lcd.ERR_FLAGS), 0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    check("frame_done_1c", 32'(lcd.FRAME_DONE), 0);
    check("frame_line0",   32'(lcd.LINE_CNT), 0);

    // line 0 with 161 pixels: overrun, 161st dropped
    for (int x = 0; x < W; x++) pix(x, 0, 2'(x + 1));
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    check("ovr_we",      32'(lcd.FB_WE), 0);
    check("ovr_addr",    32'(lcd.FB_ADDR), 32'd159);
    check("ovr_last",    32'(last_addr), 32'd159);
    check("ovr_err",     32'(lcd.ERR_FLAGS), 32'b001);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    check("ovr_clr",     32'(lcd.ERR_FLAGS), 0);
    step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    check("ovr_hs_err",  32'(lcd.ERR_FLAGS), 0);
    check("ovr_line1",   32'(lcd.LINE_CNT), 1);

    // line 1: overrun pixel in the same cycle as ERR_CLR, set wins
    for (int x = 0; x < W; x++) pix(x, 1, 2'(x));
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
    check("set_wins",    32'(lcd.ERR_FLAGS), 32'b001);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    check("set_wins_clr", 32'(lcd.ERR_FLAGS), 0);
    step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

    // line 2: last pixel together with HSYNC
    for (int x = 0; x < W - 1; x++) pix(x, 2, 2'(x));
    exp_q.push_back({15'(2 * W + 159), 2'b01});
    step(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    check("sim_addr",    32'(lcd.FB_ADDR), 32'd479);
    check("sim_err",     32'(lcd.ERR_FLAGS), 0);
    check("sim_line",    32'(lcd.LINE_CNT), 3);
    pix(0, 3, 2'b10);
    check("sim_next",    32'(lcd.FB_ADDR), 32'd480);
    // line 3 ends after one pixel: underrun
    step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    check("udr_err",     32'(lcd.ERR_FLAGS), 32'b010);
    check("udr_line",    32'(lcd.LINE_CNT), 4);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    // short frame: VSYNC at y=4
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    check("short_done",  32'(lcd.FRAME_DONE), 0);
    check("short_sel",   32'(lcd.FB_SEL), 0);
    check("short_err",   32'(lcd.ERR_FLAGS), 32'b100);
    check("short_line",  32'(lcd.LINE_CNT), 0);
    pix(0, 0, 2'b11);
    check("short_addr0", 32'(lcd.FB_ADDR), 0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    check("short_clr",   32'(lcd.ERR_FLAGS), 0);

    // advance to y=50 with bare HSYNCs, write a few pixels, drop LCD_ON
    for (int y = 0; y < 50; y++) step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    check("y50_line",    32'(lcd.LINE_CNT), 32'd50);
    check("y50_err",     32'(lcd.ERR_FLAGS), 32'b010);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int x = 0; x < 4; x++) pix(x, 50, 2'(3 - x));
    check("y50_addr",    32'(lcd.FB_ADDR), 32'd8003);
    push_clear();
    lcd.LCD_ON = 1'b0;
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    check("drop_state",  32'(lcd.DBG_STATE), 32'(S_CLEAR));
    check("drop_we",     32'(lcd.FB_WE), 0);
    wait_done(0, n);
    check("drop_cycles", n, 32'd23041);
    check("drop_sel",    32'(lcd.FB_SEL), 1);
    check("drop_state2", 32'(lcd.DBG_STATE), 32'(S_OFF));
    check("drop_all_wr", 32'(exp_q.size()), 0);

    // OFF ignores pixels; LCD_ON rise goes to WAIT_FRAME
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    check("off_state",   32'(lcd.DBG_STATE), 32'(S_OFF));
    lcd.LCD_ON = 1'b1;
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    check("on_state",    32'(lcd.DBG_STATE), 32'(S_WAIT));
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    check("on_wait",     32'(lcd.DBG_STATE), 32'(S_WAIT));
    check("on_line",     32'(lcd.LINE_CNT), 0);
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    check("on_active",   32'(lcd.DBG_STATE), 32'(S_ACTIVE));
    pix(0, 0, 2'b10);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    check("on_first",    32'({last_addr, last_data}), 32'({15'd0, 2'b10}));
    check("final_q",     32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
